lcd_char_writer: RTL and testbench



---
 rtl/lcd_char_writer.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_char_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_writer.sv
// Streams NUM_CHARS bytes from the character ROM to an HD44780 LCD (8-bit mode) after power-on init.
// Optional LCD_TWO_LINE_EN: 2-line function set, up to 32 chars, 0xC0 line-2 home before char 16.
module lcd_char_writer #(
    parameter int INIT_WAIT_CYC  = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int NUM_CHARS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic [2:0] dbg_state
);

`ifdef LCD_TWO_LINE_EN
    localparam int         MAX_CHARS = 32;
    localparam logic [7:0] FUNC_SET  = 8'h38;
`else
    localparam int         MAX_CHARS = 16;
    localparam logic [7:0] FUNC_SET  = 8'h30;
`endif

    localparam int NCH = (NUM_CHARS > MAX_CHARS) ? MAX_CHARS : ((NUM_CHARS < 1) ? 1 : NUM_CHARS);

    localparam int M1      = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int M2      = (M1 > CMD_WAIT_CYC) ? M1 : CMD_WAIT_CYC;
    localparam int M3      = (M2 > E_PULSE_CYC) ? M2 : E_PULSE_CYC;
    localparam int MAX_CYC = (M3 > SETUP_CYC) ? M3 : SETUP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, HOME, CHAR, LINE2, DONE
    } state_t;

    // LOAD is the one cycle where char_addr has settled and the byte is captured.
    typedef enum logic [1:0] {
        PH_LOAD, PH_SETUP, PH_PULSE, PH_HOLD
    } phase_t;

    state_t        state, state_nxt;
    phase_t        phase, phase_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    init_idx, init_idx_nxt;
    logic [4:0]    char_addr_nxt;
    logic          busy_nxt, done_nxt, pending, pending_nxt;
    logic          lcd_rs_nxt, lcd_e_nxt;
    logic [7:0]    lcd_data_nxt;

    logic [7:0]    wr_byte;
    logic          wr_rs;
    logic          is_wr;
    logic          wr_done;
    logic [CW-1:0] hold_last;

    // Handshake: start is a one-cycle request; busy stays high from acceptance
    // until done pulses, and requests seen while busy collapse into one pending refresh.
    assign lcd_rw    = 1'b0;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            phase     <= PH_LOAD;
            cnt       <= '0;
            init_idx  <= '0;
            char_addr <= '0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
            pending   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            init_idx  <= init_idx_nxt;
            char_addr <= char_addr_nxt;
            lcd_rs    <= lcd_rs_nxt;
            lcd_e     <= lcd_e_nxt;
            lcd_data  <= lcd_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pending   <= pending_nxt;
        end
    end

    always_comb begin
        wr_byte = 8'h00;
        wr_rs   = 1'b0;
        case (state)
            INIT: begin
                case (init_idx)
                    2'd0:    wr_byte = FUNC_SET;
                    2'd1:    wr_byte = 8'h0C;
                    2'd2:    wr_byte = 8'h06;
                    default: wr_byte = 8'h01;
                endcase
            end
            HOME:    wr_byte = 8'h80;
            LINE2:   wr_byte = 8'hC0;
            CHAR: begin
                wr_byte = char_data;
                wr_rs   = 1'b1;
            end
            default: wr_byte = 8'h00;
        endcase
    end

    assign is_wr     = (state == INIT) || (state == HOME) || (state == CHAR) || (state == LINE2);
    assign hold_last = (lcd_data == 8'h01) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
    assign wr_done   = is_wr && (phase == PH_HOLD) && (cnt == hold_last);

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        cnt_nxt       = cnt;
        init_idx_nxt  = init_idx;
        char_addr_nxt = char_addr;
        lcd_rs_nxt    = lcd_rs;
        lcd_e_nxt     = lcd_e;
        lcd_data_nxt  = lcd_data;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        pending_nxt   = pending | (start & (busy | (state == DONE)));

        if (is_wr) begin
            case (phase)
                PH_LOAD: begin
                    lcd_data_nxt = wr_byte;
                    lcd_rs_nxt   = wr_rs;
                    phase_nxt    = PH_SETUP;
                    cnt_nxt      = '0;
                end
                PH_SETUP: begin
                    if (cnt == CW'(SETUP_CYC - 1)) begin
                        phase_nxt = PH_PULSE;
                        cnt_nxt   = '0;
                        lcd_e_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                PH_PULSE: begin
                    if (cnt == CW'(E_PULSE_CYC - 1)) begin
                        phase_nxt = PH_HOLD;
                        cnt_nxt   = '0;
                        lcd_e_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    if (wr_done) begin
                        phase_nxt = PH_LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            endcase
        end

        case (state)
            PWR_WAIT: begin
                if (cnt == CW'(INIT_WAIT_CYC - 1)) begin
                    state_nxt    = INIT;
                    phase_nxt    = PH_LOAD;
                    cnt_nxt      = '0;
                    init_idx_nxt = 2'd0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (init_idx == 2'd3) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (start || pending) begin
                    state_nxt   = HOME;
                    busy_nxt    = 1'b1;
                    pending_nxt = 1'b0;
                end
            end
            HOME: begin
                if (wr_done) begin
                    state_nxt     = CHAR;
                    char_addr_nxt = 5'd0;
                end
            end
            CHAR: begin
                if (wr_done) begin
                    if (char_addr == 5'(NCH - 1)) begin
                        state_nxt     = DONE;
                        done_nxt      = 1'b1;
                        busy_nxt      = 1'b0;
                        char_addr_nxt = 5'd0;
`ifdef LCD_TWO_LINE_EN
                    end else if ((NCH > 16) && (char_addr == 5'd15)) begin
                        // Address moves now so it is settled long before the next capture.
                        state_nxt     = LINE2;
                        char_addr_nxt = 5'd16;
`endif
                    end else begin
                        char_addr_nxt = char_addr + 5'd1;
                    end
                end
            end
            LINE2: begin
                if (wr_done) begin
                    state_nxt = CHAR;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = PWR_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer: random ROM contents, LCD bus monitor, write scoreboard.
module tb_lcd_char_writer;

    localparam int INIT_WAIT = 20;
    localparam int SETUP     = 2;
    localparam int EPULSE    = 3;
    localparam int CMDW      = 5;
    localparam int CLRW      = 10;
`ifdef LCD_TWO_LINE_EN
    localparam int         NCH  = 20;
    localparam logic [7:0] FUNC = 8'h38;
`else
    localparam int         NCH  = 4;
    localparam logic [7:0] FUNC = 8'h30;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [2:0] dbg_state;

    logic [7:0] rom [32];
    logic       glitch;

    // ROM is combinational on the address; glitch mode corrupts it while E is high.
    assign char_data = (glitch && lcd_e) ? (rom[char_addr] ^ 8'hFF) : rom[char_addr];

    lcd_char_writer #(
        .INIT_WAIT_CYC (INIT_WAIT),
        .SETUP_CYC     (SETUP),
        .E_PULSE_CYC   (EPULSE),
        .CMD_WAIT_CYC  (CMDW),
        .CLEAR_WAIT_CYC(CLRW),
        .NUM_CHARS     (NCH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .char_addr(char_addr),
        .char_data(char_data),
        .busy     (busy),
        .done     (done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, FUNC});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_refresh();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < NCH; i++) begin
            if (i == 16) exp_q.push_back({1'b0, 8'hC0});
            exp_q.push_back({1'b1, rom[i]});
        end
    endtask

    // ---------------- bus monitor ----------------
    int         low_cnt, hi_cnt, stable_cnt, need_lo, hold_req, done_len;
    int         done_cnt = 0;
    int         wr_cnt   = 0;
    logic       prev_e, prev_done, idle_seen;
    logic [8:0] prev_rsd, cur;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt    = 0;
            hi_cnt     = 0;
            stable_cnt = 0;
            need_lo    = INIT_WAIT + SETUP;
            hold_req   = 0;
            done_len   = 0;
            prev_e     = 1'b0;
            prev_done  = 1'b0;
            idle_seen  = 1'b0;
            prev_rsd   = 9'h000;
        end else begin
            cur = {lcd_rs, lcd_data};
            if (!busy) idle_seen = 1'b1;
            if (cur != prev_rsd) begin
                if (lcd_e)
                    check("bus_change_while_e_high", 32'(cur), 32'(prev_rsd));
                else if (low_cnt < hold_req)
                    check("bus_change_in_hold", 32'(low_cnt), 32'(hold_req));
                stable_cnt = 1;
            end else begin
                stable_cnt++;
            end

            if (lcd_e && !prev_e) begin
                check($sformatf("e_low_gap lo=%0d need=%0d", low_cnt, need_lo),
                      ((low_cnt >= need_lo) && (idle_seen || low_cnt <= need_lo + 2)) ? 1 : 0, 1);
                check($sformatf("setup_stable cyc=%0d", stable_cnt - 1),
                      (stable_cnt - 1 >= SETUP) ? 1 : 0, 1);
                check("busy_in_write", 32'(busy), 1);
                check("rw_low", 32'(lcd_rw), 0);
                if (exp_q.size() == 0)
                    check("write_extra", 32'(cur), 32'hFFFF_FFFF);
                else
                    check($sformatf("write#%0d", wr_cnt), 32'(cur), 32'(exp_q.pop_front()));
                wr_cnt++;
                hi_cnt    = 1;
                low_cnt   = 0;
                idle_seen = 1'b0;
            end else if (lcd_e) begin
                hi_cnt++;
            end else if (prev_e) begin
                check("e_width", 32'(hi_cnt), 32'(EPULSE));
                hold_req = (lcd_data == 8'h01) ? CLRW : CMDW;
                need_lo  = hold_req + SETUP;
                low_cnt  = 1;
            end else begin
                low_cnt++;
            end

            if (done && !prev_done) begin
                done_cnt++;
                done_len = 1;
            end else if (done) begin
                done_len++;
            end else if (prev_done) begin
                check("done_width", 32'(done_len), 1);
            end
            prev_e    = lcd_e;
            prev_done = done;
            prev_rsd  = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int target, input int budget);
        int n = 0;
        while ((done_cnt < target || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_budget"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lcd_e"}, 32'(lcd_e), 0);
        check({tag, "_lcd_data"}, 32'(lcd_data), 0);
        check({tag, "_lcd_rs"}, 32'(lcd_rs), 0);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_char_addr"}, 32'(char_addr), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        glitch = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'(8'h40 + i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        check("reset_rw", 32'(lcd_rw), 0);

        // power-on init, with a start request arriving during PWR_WAIT afterwards checked separately
        @(posedge clk); #1 rst = 1'b0;
        push_init();
        wait_idle("init", 0, 600);
        check("init_queue_empty", 32'(exp_q.size()), 0);
        check("init_write_count", 32'(wr_cnt), 4);

        // first refresh with the 0x40+addr ROM
        push_refresh();
        pulse_start();
        wait_idle("refresh1", 1, 4000);
        repeat (5) @(negedge clk);
        check("refresh1_queue_empty", 32'(exp_q.size()), 0);
        check("refresh1_done_count", 32'(done_cnt), 1);
        check("refresh1_addr_back_to_0", 32'(char_addr), 0);

        // extra starts while busy collapse into exactly one further refresh
        randomize_rom();
        push_refresh();
        push_refresh();
        pulse_start();
        repeat ($urandom_range(3, 40)) @(posedge clk);
        pulse_start();
        repeat ($urandom_range(1, 10)) @(posedge clk);
        pulse_start();
        wait_idle("pending", 3, 6000);
        repeat (60) @(negedge clk);
        check("pending_done_count", 32'(done_cnt), 3);
        check("pending_queue_empty", 32'(exp_q.size()), 0);
        check("pending_busy_low", 32'(busy), 0);

        // ROM output changes while E is high must not reach the bus
        randomize_rom();
        glitch = 1'b1;
        push_refresh();
        pulse_start();
        wait_idle("glitch", 4, 4000);
        glitch = 1'b0;
        check("glitch_queue_empty", 32'(exp_q.size()), 0);

        // reset in the middle of a character pulse
        randomize_rom();
        push_refresh();
        pulse_start();
        n = 0;
        while (!(lcd_e && lcd_rs) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("found_char_pulse", (n < 2000) ? 1 : 0, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_values("midwrite_reset");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        n = wr_cnt;
        push_init();
        wait_idle("reinit", 4, 600);
        check("reinit_queue_empty", 32'(exp_q.size()), 0);
        check("reinit_write_count", 32'(wr_cnt - n), 4);

        // a start issued during power-on wait is served once init finishes
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        push_init();
        randomize_rom();
        push_refresh();
        repeat ($urandom_range(2, 15)) @(posedge clk);
        pulse_start();
        wait_idle("start_in_pwr_wait", 5, 6000);
        repeat (20) @(negedge clk);
        check("pwr_wait_start_queue_empty", 32'(exp_q.size()), 0);
        check("pwr_wait_start_done_count", 32'(done_cnt), 5);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
